// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: digit count, idle
// patterns and the active-low hex glyph table in {g,f,e,d,c,b,a} order.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    localparam logic [6:0] HEX_GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [7:0] anode_select(input logic [2:0] idx);
        return ~(8'h01 << idx);
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_GLYPHS[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// 8-digit multiplexed seven-segment driver with frame-synchronous double
// buffering, per-slot anti-ghost blanking and optional leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int              DIV_W     = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
    localparam logic [2:0]       IDX_LAST  = 3'(NUM_DIGITS - 1);

    logic [DIV_W-1:0] div;
    logic [2:0]       idx;
    logic [31:0]      shadow;
    logic [31:0]      active;
    logic             pending;

    logic       tc;
    logic       wrap;
    logic [3:0] cur_nibble;
    logic [6:0] cur_glyph;
    logic       upper_zero;
    logic       suppress;
    logic       in_blank;

    assign tc         = (div == DIV_LAST);
    assign wrap       = tc && (idx == IDX_LAST);
    assign cur_nibble = active[{idx, 2'b00} +: 4];
    assign in_blank   = (div < BLANK_END);
    assign suppress   = blank_lz && (idx != 3'd0) && upper_zero;
    assign dp         = 1'b1;

    // A digit is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((i >= int'(idx)) && (active[4*i +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
    end

    hex7seg u_hex7seg (
        .nibble (cur_nibble),
        .seg    (cur_glyph)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
            idx <= '0;
        end else if (tc) begin
            div <= '0;
            idx <= idx + 3'd1;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Active only changes at the frame wrap so a frame never mixes two words;
    // a load coinciding with the wrap bypasses the shadow to avoid a frame of lag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (wrap && load) begin
                active  <= data_in;
                shadow  <= data_in;
                pending <= 1'b0;
            end else begin
                if (load) begin
                    shadow  <= data_in;
                    pending <= 1'b1;
                end
                if (wrap && pending) begin
                    active  <= shadow;
                    pending <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else if (in_blank || suppress) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= anode_select(idx);
            seg <= cur_glyph;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with REFRESH_DIV=4, BLANK_CYC=1:
// expected per-cycle outputs are queued by the stimulus and popped by a monitor.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst;
    logic [31:0] data_in;
    logic        load;
    logic        blank_lz;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   mon_count  = 0;
    int   edge_n     = 0;

    logic [6:0] glyph [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seg7_scan_driver #(
        .REFRESH_DIV (4),
        .BLANK_CYC   (1)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int id, input exp_t e);
        vectors++;
        if ({an, seg, dp, frame_done} !== {e.an, e.seg, 1'b1, e.fd}) begin
            miscompares++;
            $display("[TB] FAIL %s #%0d: got an=%h seg=%h dp=%b fd=%b, expected an=%h seg=%h dp=1 fd=%b",
                     name, id, an, seg, dp, frame_done, e.an, e.seg, e.fd);
        end
    endtask

    // Each frame is 8 slots of 4 cycles: one blank cycle, then three lit cycles.
    task automatic push_frame(input logic [31:0] word, input logic lz, input int n);
        exp_t e;
        for (int j = 0; j < n; j++) begin
            int   s;
            int   pos;
            logic upper;
            logic lit;
            s     = j / 4;
            pos   = j % 4;
            upper = ((word >> (4 * s)) == 32'h0);
            lit   = (pos != 0) && !(lz && (s != 0) && upper);
            e.an  = lit ? (8'hFF ^ (8'h01 << s)) : 8'hFF;
            e.seg = lit ? glyph[word[4*s +: 4]] : 7'h7F;
            e.fd  = (j == 31);
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
        edge_n += n;
    endtask

    task automatic apply_stimulus(input logic [31:0] word, input int at_edge);
        step(at_edge - 1 - edge_n);
        data_in = word;
        load    = 1'b1;
        step(1);
        load    = 1'b0;
    endtask

    task automatic set_lz(input int at_edge, input logic v);
        step(at_edge - edge_n);
        blank_lz = v;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check_output("slot", mon_count, exp_q.pop_front());
            mon_count++;
        end
    end

    initial begin
        exp_t rst_e;
        rst_e    = '{an: 8'hFF, seg: 7'h7F, fd: 1'b0};
        rst      = 1'b1;
        data_in  = 32'h0;
        load     = 1'b0;
        blank_lz = 1'b0;
        #1;
        check_output("reset_state", 0, rst_e);

        @(posedge clk);
        #1;
        rst    = 1'b0;
        edge_n = 0;
        step(1);

        push_frame(32'h00000000, 1'b0, 32);
        push_frame(32'h00000000, 1'b1, 32);
        push_frame(32'h1234ABCD, 1'b0, 32);
        push_frame(32'h0000BEEF, 1'b1, 32);
        push_frame(32'hDEADBEEF, 1'b0, 32);
        push_frame(32'hDEADBEEF, 1'b0, 21);

        set_lz(32, 1'b1);
        apply_stimulus(32'h1234ABCD, 45);
        set_lz(64, 1'b0);
        apply_stimulus(32'h11111111, 70);
        apply_stimulus(32'h0000BEEF, 80);
        set_lz(96, 1'b1);
        apply_stimulus(32'hDEADBEEF, 128);
        blank_lz = 1'b0;

        vectors++;
        if (u_dut.pending !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bypass_pending: got %b, expected 0", u_dut.pending);
        end

        // Leave a load pending, then reset in the middle of the digit-5 slot.
        apply_stimulus(32'h87654321, 170);
        step(182 - edge_n);
        rst = 1'b1;
        #1;
        check_output("reset_mid_frame", 0, rst_e);
        step(2);
        check_output("reset_held", 0, rst_e);

        rst    = 1'b0;
        edge_n = 0;
        step(1);
        push_frame(32'h00000000, 1'b0, 32);
        push_frame(32'h00000000, 1'b0, 32);

        for (int k = 0; k < 200 && exp_q.size() > 0; k++) begin
            @(negedge clk);
        end
        step(1);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain_timeout: got %0d entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
